// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared constants for the MEM pipeline stage:
//   - funct3 load/store size/sign codes (F3_B/H/W/BU/HU)
//   - MEM_BE_WIDTH, width of the data-memory byte-enable bus
//   - MEM FSM state encodings
//   - access_size(): maps funct3 to byte/half/word (undefined codes -> word)
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int MEM_BE_WIDTH = 4;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

   // Anything that is not an explicit byte/half code is treated as a word.
   function automatic logic [1:0] access_size(input logic [2:0] f3);
      logic [1:0] sz;
      case (f3)
         F3_B, F3_BU: sz = SIZE_BYTE;
         F3_H, F3_HU: sz = SIZE_HALF;
         F3_W:        sz = SIZE_WORD;
         default:     sz = SIZE_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// ---------------------------------------------------------------------------
// load_store_align
// Combinational lane steering for the MEM stage.
//   funct3     in   access size/sign
//   off        in   byte offset within the word (addr[1:0])
//   store_data in   raw store operand
//   rdata      in   raw word returned by data memory
//   be         out  byte enables for the store
//   wdata      out  lane-replicated store data
//   load_ext   out  selected and sign/zero-extended load result
//   misaligned out  half with off[0]=1, or word with off!=0
// ---------------------------------------------------------------------------
module load_store_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]              funct3,
   input  logic [1:0]              off,
   input  logic [DATA_WIDTH-1:0]   store_data,
   input  logic [DATA_WIDTH-1:0]   rdata,
   output logic [MEM_BE_WIDTH-1:0] be,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   load_ext,
   output logic                    misaligned
);

   logic [1:0]  size;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        is_unsigned;

   assign size        = access_size(funct3);
   assign is_unsigned = funct3[2];

   always_comb begin
      ld_byte = rdata[7:0];
      case (off)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half = off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      be         = 4'b1111;
      wdata      = store_data;
      load_ext   = rdata;
      misaligned = 1'b0;
      case (size)
         SIZE_BYTE: begin
            be       = 4'b0001 << off;
            wdata    = {4{store_data[7:0]}};
            load_ext = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                   : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         end
         SIZE_HALF: begin
            be         = 4'b0011 << {off[1], 1'b0};
            wdata      = {2{store_data[15:0]}};
            load_ext   = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                     : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            misaligned = off[0];
         end
         default: begin
            be         = 4'b1111;
            wdata      = store_data;
            load_ext   = rdata;
            misaligned = (off != 2'd0);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Pipeline MEM stage: issues data-memory requests, stalls upstream until the
// access is acknowledged, and registers results into MEM/WB.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses skip memory and report through
//               a one-cycle misalign pulse with wb_data = faulting address
//   undefined - misalign tied to 0, low address bits silently ignored
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ex_valid          EX/MEM holds a valid instruction
//   mem_read/write    load / store (both set -> store)
//   funct3            access size/sign
//   alu_result        address or ALU value
//   store_data        forwarded rs2
//   rd_in             destination register
//   reg_write_in      writeback enable
//   stall             hold PC, IF/ID, ID/EX, EX/MEM
//   dmem_*            request/acknowledge data-memory port
//   wb_*              MEM/WB register outputs
//   misalign          misaligned-access pulse
//
// state  | meaning
// IDLE   | no access in flight; non-memory ops pass through in one cycle
// ACCESS | request held on dmem_* until dmem_ack
// ---------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_WIDTH   = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ex_valid,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [2:0]              funct3,
   input  logic [DATA_WIDTH-1:0]   alu_result,
   input  logic [DATA_WIDTH-1:0]   store_data,
   input  logic [RD_WIDTH-1:0]     rd_in,
   input  logic                    reg_write_in,
   output logic                    stall,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [ADDR_WIDTH-1:0]   dmem_addr,
   output logic [DATA_WIDTH-1:0]   dmem_wdata,
   output logic [MEM_BE_WIDTH-1:0] dmem_be,
   input  logic                    dmem_ack,
   input  logic [DATA_WIDTH-1:0]   dmem_rdata,
   output logic                    wb_valid,
   output logic [DATA_WIDTH-1:0]   wb_data,
   output logic [RD_WIDTH-1:0]     wb_rd,
   output logic                    wb_reg_write,
   output logic                    misalign
);

   mem_state_e state_q, state_d;

   logic                    mem_op;
   logic                    trap;
   logic                    in_access;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [2:0]              req_funct3;
   logic [RD_WIDTH-1:0]     req_rd;
   logic                    req_reg_write;
   logic                    misalign_q;

   logic [2:0]              al_funct3;
   logic [1:0]              al_off;
   logic [MEM_BE_WIDTH-1:0] al_be;
   logic [DATA_WIDTH-1:0]   al_wdata;
   logic [DATA_WIDTH-1:0]   al_load_ext;
   logic                    al_misaligned;

   assign in_access = (state_q == ST_ACCESS);
   assign mem_op    = ex_valid & (mem_read | mem_write);

   // One aligner serves both directions: in IDLE it steers the incoming
   // store, in ACCESS it extracts load data using the captured request.
   assign al_funct3 = in_access ? req_funct3    : funct3;
   assign al_off    = in_access ? req_addr[1:0] : alu_result[1:0];

   load_store_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .funct3     (al_funct3),
      .off        (al_off),
      .store_data (store_data),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_ext   (al_load_ext),
      .misaligned (al_misaligned)
   );

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap     = ~in_access & mem_op & al_misaligned;
   assign misalign = misalign_q;
`else
   logic unused_misaligned;
   assign unused_misaligned = al_misaligned ^ misalign_q;
   assign trap     = 1'b0;
   assign misalign = 1'b0;
`endif

   assign stall     = (~in_access & mem_op & ~trap) | (in_access & ~dmem_ack);
   assign dmem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (mem_op && !trap) state_d = ST_ACCESS;
         ST_ACCESS: if (dmem_ack)        state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_wdata    <= '0;
         dmem_be       <= '0;
         req_addr      <= '0;
         req_funct3    <= '0;
         req_rd        <= '0;
         req_reg_write <= 1'b0;
         wb_valid      <= 1'b0;
         wb_data       <= '0;
         wb_rd         <= '0;
         wb_reg_write  <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         if (!in_access) begin
            if (mem_op && !trap) begin
               req_addr      <= alu_result[ADDR_WIDTH-1:0];
               req_funct3    <= funct3;
               req_rd        <= rd_in;
               req_reg_write <= reg_write_in;
               dmem_req      <= 1'b1;
               dmem_we       <= mem_write;
               dmem_be       <= al_be;
               dmem_wdata    <= al_wdata;
               wb_valid      <= 1'b0;
            end else if (mem_op) begin
               misalign_q   <= 1'b1;
               wb_valid     <= 1'b1;
               wb_data      <= alu_result;
               wb_rd        <= rd_in;
               wb_reg_write <= 1'b0;
            end else if (ex_valid) begin
               wb_valid     <= 1'b1;
               wb_data      <= alu_result;
               wb_rd        <= rd_in;
               wb_reg_write <= reg_write_in;
            end else begin
               wb_valid <= 1'b0;
            end
         end else begin
            wb_valid <= 1'b0;
            if (dmem_ack) begin
               dmem_req     <= 1'b0;
               wb_valid     <= 1'b1;
               wb_rd        <= req_rd;
               // A store writes back nothing; its address is reported instead.
               wb_data      <= dmem_we ? DATA_WIDTH'(req_addr) : al_load_ext;
               wb_reg_write <= dmem_we ? 1'b0 : req_reg_write;
            end
         end
      end
   end

endmodule
